// File: rtl/bsg_mul_issue_ctrl.sv
// bsg_mul_issue_ctrl: issues one multiply request at a time to an external multiplier and returns the selected product half
module bsg_mul_issue_ctrl #(
  parameter int width_p     = 32,
  parameter int tag_width_p = 5
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [width_p-1:0]       opA_i,
  input  logic [width_p-1:0]       opB_i,
  input  logic [tag_width_p-1:0]   tag_i,
  output logic                     mul_v_o,
  input  logic                     mul_ready_i,
  output logic [width_p-1:0]       mul_opA_o,
  output logic [width_p-1:0]       mul_opB_o,
  output logic                     mul_opA_is_signed_o,
  output logic                     mul_opB_is_signed_o,
  input  logic [2*width_p-1:0]     mul_result_i,
  input  logic                     mul_v_i,
  output logic                     mul_yumi_o,
  output logic                     v_o,
  output logic [width_p-1:0]       result_o,
  output logic [tag_width_p-1:0]   tag_o,
  input  logic                     yumi_i
);
  typedef enum logic [1:0] {eIDLE, eISSUE, eWAIT, eDONE} state_e;
  state_e state_r, state_n;
  logic live_r;
  logic [1:0] op_r;
  logic [width_p-1:0] a_r, b_r, res_r;
  logic [tag_width_p-1:0] tag_r;
  logic accept, bypass;
  // live_r holds ready/yumi low during reset and rises on the first edge after release
  always_comb begin
    state_n    = state_r;
    ready_o    = live_r && state_r == eIDLE && !mul_v_i;
    mul_yumi_o = live_r && mul_v_i && (state_r == eIDLE || state_r == eWAIT);
    mul_v_o    = state_r == eISSUE;
    v_o        = state_r == eDONE;
    accept     = v_i && ready_o;
    bypass     = opA_i == '0 || opB_i == '0;
    case (state_r)
      eIDLE:  state_n = accept ? (bypass ? eDONE : eISSUE) : eIDLE;
      eISSUE: state_n = mul_ready_i ? eWAIT : eISSUE;
      eWAIT:  state_n = mul_v_i ? eDONE : eWAIT;
      eDONE:  state_n = yumi_i ? eIDLE : eDONE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIDLE;
      live_r  <= 1'b0;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      tag_r   <= '0;
      res_r   <= '0;
    end else begin
      state_r <= state_n;
      live_r  <= 1'b1;
      if (accept) begin
        op_r  <= op_i;
        a_r   <= opA_i;
        b_r   <= opB_i;
        tag_r <= tag_i;
        res_r <= '0;
      end
      if (state_r == eWAIT && mul_v_i)
        res_r <= op_r == 2'b00 ? mul_result_i[width_p-1:0] : mul_result_i[2*width_p-1:width_p];
    end
  end
  assign mul_opA_o           = a_r;
  assign mul_opB_o           = b_r;
  assign mul_opA_is_signed_o = op_r == 2'b01 || op_r == 2'b10;
  assign mul_opB_is_signed_o = op_r == 2'b01;
  assign result_o            = res_r;
  assign tag_o               = tag_r;
endmodule

// File: tb/tb_bsg_mul_issue_ctrl.sv
// tb_bsg_mul_issue_ctrl: vector table plus scoreboard against a behavioural multiplier and response consumer
module tb_bsg_mul_issue_ctrl;
  logic clk_i = 1'b0, reset_n_i = 1'b0, v_i = 1'b0, ready_o;
  logic [1:0] op_i = '0;
  logic [31:0] opA_i = '0, opB_i = '0;
  logic [4:0] tag_i = '0;
  logic mul_v_o, mul_ready_i = 1'b0;
  logic [31:0] mul_opA_o, mul_opB_o;
  logic mul_opA_is_signed_o, mul_opB_is_signed_o;
  logic [63:0] mul_result_i = '0;
  logic mul_v_i = 1'b0, mul_yumi_o, v_o;
  logic [31:0] result_o;
  logic [4:0] tag_o;
  logic yumi_i = 1'b0;

  always #5 clk_i = ~clk_i;

  bsg_mul_issue_ctrl #(.width_p(32), .tag_width_p(5)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .opA_i(opA_i), .opB_i(opB_i), .tag_i(tag_i),
    .mul_v_o(mul_v_o), .mul_ready_i(mul_ready_i), .mul_opA_o(mul_opA_o), .mul_opB_o(mul_opB_o),
    .mul_opA_is_signed_o(mul_opA_is_signed_o), .mul_opB_is_signed_o(mul_opB_is_signed_o),
    .mul_result_i(mul_result_i), .mul_v_i(mul_v_i), .mul_yumi_o(mul_yumi_o),
    .v_o(v_o), .result_o(result_o), .tag_o(tag_o), .yumi_i(yumi_i)
  );

  typedef struct {
    logic [1:0] op; logic [31:0] a, b; logic [4:0] tag;
    int istall, lat, ystall; bit fy, byp, sa, sb; logic [31:0] exp;
  } vec_t;
  typedef struct { logic [31:0] res; logic [4:0] tag; } sb_t;
  sb_t sb[$];
  vec_t tv[12];
  int checks = 0, fails = 0, cyc = 0;
  int istall_left = 0, ystall_left = 0, mul_lat = 0, m_cnt = 0;
  int acc_cyc = 0, ret_cyc = 0, vrise_cyc = 0, n_rsp = 0, n_iss = 0;
  bit m_busy = 0, force_yumi = 0, inflight = 0, bad_rdy = 0, bad_stab = 0, saw_mulv = 0;
  bit prev_mulv = 0, prev_vo = 0;
  logic [63:0] m_res = '0;
  logic [31:0] pa = '0, pb = '0, pres = '0, last_res = '0;
  logic [4:0] ptag = '0;
  logic psa = 1'b0, psb = 1'b0, last_sa = 1'b0, last_sb = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb_);
    logic signed [129:0] ea, eb, p;
    ea = sa ? 130'($signed(a)) : 130'(a);
    eb = sb_ ? 130'($signed(b)) : 130'(b);
    p = ea * eb;
    return p[63:0];
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b00: begin p = prod(a, b, 1'b0, 1'b0); return p[31:0]; end
      2'b01: p = prod(a, b, 1'b1, 1'b1);
      2'b10: p = prod(a, b, 1'b1, 1'b0);
      default: p = prod(a, b, 1'b0, 1'b0);
    endcase
    return p[63:32];
  endfunction

  // sample handshakes at negedge, then drive the next cycle's inputs just after posedge
  task automatic tick();
    bit acc, iss, ret, rsp;
    sb_t e;
    cyc++;
    acc = v_i && ready_o;
    iss = mul_v_o && mul_ready_i;
    ret = mul_v_i && mul_yumi_o;
    rsp = v_o && yumi_i;
    if (inflight && ready_o) bad_rdy = 1;
    if (mul_v_o) saw_mulv = 1;
    if (mul_v_o && prev_mulv && {pa, pb, psa, psb} !== {mul_opA_o, mul_opB_o, mul_opA_is_signed_o, mul_opB_is_signed_o}) bad_stab = 1;
    if (v_o && prev_vo && {pres, ptag} !== {result_o, tag_o}) bad_stab = 1;
    if (v_o && !prev_vo) vrise_cyc = cyc;
    prev_mulv = mul_v_o; prev_vo = v_o;
    pa = mul_opA_o; pb = mul_opB_o; psa = mul_opA_is_signed_o; psb = mul_opB_is_signed_o;
    pres = result_o; ptag = tag_o;
    if (acc) begin
      e.res = ref_res(op_i, opA_i, opB_i);
      e.tag = tag_i;
      sb.push_back(e);
      acc_cyc = cyc;
      inflight = 1;
    end
    if (iss) begin
      m_res = prod(mul_opA_o, mul_opB_o, mul_opA_is_signed_o, mul_opB_is_signed_o);
      m_cnt = mul_lat; m_busy = 1;
      last_sa = mul_opA_is_signed_o; last_sb = mul_opB_is_signed_o;
      n_iss++;
    end
    if (ret) ret_cyc = cyc;
    if (rsp) begin
      n_rsp++; inflight = 0; last_res = result_o;
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_rsp: got tag %0d result %0h, no response required", tag_o, result_o);
      end else begin
        e = sb.pop_front();
        chk("sb_result", 128'(result_o), 128'(e.res));
        chk("sb_tag", 128'(tag_o), 128'(e.tag));
      end
    end
    @(posedge clk_i); #1;
    if (acc) v_i = 1'b0;
    if (ret) mul_v_i = 1'b0;
    if (m_busy) begin
      if (m_cnt == 0) begin mul_v_i = 1'b1; mul_result_i = m_res; m_busy = 0; end
      else m_cnt--;
    end
    if (mul_v_o && istall_left > 0) begin mul_ready_i = 1'b0; istall_left--; end
    else mul_ready_i = mul_v_o;
    if (v_o && ystall_left > 0) begin yumi_i = force_yumi; ystall_left--; end
    else yumi_i = v_o | force_yumi;
  endtask

  task automatic step();
    @(negedge clk_i);
    tick();
  endtask

  task automatic wait_rsp(input string name);
    int n0, k;
    n0 = n_rsp; k = 0;
    while (n_rsp == n0 && k < 200) begin step(); k++; end
    if (n_rsp == n0) begin
      checks++; fails++;
      $display("FAIL %s_timeout: got no response in %0d cycles, 1 required", name, k);
    end
  endtask

  task automatic run_req(input vec_t v, input string name);
    op_i = v.op; opA_i = v.a; opB_i = v.b; tag_i = v.tag; v_i = 1'b1;
    istall_left = v.istall; mul_lat = v.lat; ystall_left = v.ystall; force_yumi = v.fy;
    bad_rdy = 0; bad_stab = 0; saw_mulv = 0;
    wait_rsp(name);
    chk({name, "_result"}, 128'(last_res), 128'(v.exp));
    chk({name, "_latency"}, 128'(vrise_cyc - acc_cyc), 128'(v.byp ? 1 : 3 + v.istall + v.lat));
    if (v.byp) chk({name, "_no_mul_v"}, 128'(saw_mulv), 128'(0));
    else begin
      chk({name, "_signs"}, 128'({last_sa, last_sb}), 128'({v.sa, v.sb}));
      chk({name, "_no_bubble"}, 128'(vrise_cyc - ret_cyc), 128'(1));
    end
    chk({name, "_ready_low"}, 128'(bad_rdy), 128'(0));
    chk({name, "_stable"}, 128'(bad_stab), 128'(0));
    force_yumi = 0;
    step();
  endtask

  initial begin
    //       op     a             b             tag   ist lat yst fy byp sa sb exp
    tv[0] = '{2'b01, 32'hFFFFFFFE, 32'h3,        5'd4,  0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF};
    tv[1] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFE};
    tv[2] = '{2'b00, 32'd7,        32'd6,        5'd2,  1, 0, 0, 1, 0, 0, 0, 32'd42};
    tv[3] = '{2'b10, 32'hFFFFFFFF, 32'h2,        5'd3,  0, 2, 1, 0, 0, 1, 0, 32'hFFFFFFFF};
    tv[4] = '{2'b00, 32'h0,        32'h1234,     5'd9,  0, 0, 0, 1, 1, 0, 0, 32'h0};
    tv[5] = '{2'b01, 32'h1234,     32'h0,        5'd10, 0, 0, 2, 0, 1, 0, 0, 32'h0};
    tv[6] = '{2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd17, 3, 0, 5, 0, 0, 0, 0, 32'h0};
    tv[7] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd20, 0, 4, 0, 0, 0, 1, 0, 32'h80000000};
    tv[8] = '{2'b01, 32'h80000000, 32'h80000000, 5'd31, 2, 1, 0, 0, 0, 1, 1, 32'h40000000};
    tv[9] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  0, 0, 0, 0, 0, 0, 0, 32'h1};
    tv[6].exp = ref_res(tv[6].op, tv[6].a, tv[6].b);
    for (int i = 10; i < 12; i++) begin
      tv[i].op = 2'($urandom_range(0, 3));
      tv[i].a = $urandom | 32'h100; tv[i].b = $urandom | 32'h1; tv[i].tag = 5'(i);
      tv[i].istall = $urandom_range(0, 2); tv[i].lat = $urandom_range(0, 3); tv[i].ystall = $urandom_range(0, 2);
      tv[i].fy = 0; tv[i].byp = 0;
      tv[i].sa = tv[i].op == 2'b01 || tv[i].op == 2'b10; tv[i].sb = tv[i].op == 2'b01;
      tv[i].exp = ref_res(tv[i].op, tv[i].a, tv[i].b);
    end
    mul_v_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", 128'({ready_o, v_o, mul_v_o, mul_yumi_o, mul_opA_is_signed_o, mul_opB_is_signed_o}), 128'(0));
    chk("rst_data", 128'({result_o, tag_o, mul_opA_o, mul_opB_o}), 128'(0));
    mul_v_i = 1'b0;
    #1 reset_n_i = 1'b1;
    #1 chk("rdy_before_edge", 128'(ready_o), 128'(0));
    @(posedge clk_i); #1;
    chk("rdy_after_edge", 128'(ready_o), 128'(1));
    for (int i = 0; i < 12; i++) run_req(tv[i], $sformatf("vec%0d", i));
    // abandon a request sitting in eWAIT, then hand the controller a stale product
    op_i = 2'b00; opA_i = 32'd5; opB_i = 32'd5; tag_i = 5'd7; v_i = 1'b1;
    mul_lat = 30; istall_left = 0; ystall_left = 0;
    begin
      int n0, k;
      n0 = n_iss; k = 0;
      while (n_iss == n0 && k < 50) begin step(); k++; end
      chk("midrst_issued", 128'(n_iss - n0), 128'(1));
    end
    step(); step();
    reset_n_i = 1'b0;
    #1;
    chk("midrst_ctrl", 128'({ready_o, v_o, mul_v_o, mul_yumi_o, mul_opA_is_signed_o, mul_opB_is_signed_o}), 128'(0));
    chk("midrst_data", 128'({result_o, tag_o, mul_opA_o, mul_opB_o}), 128'(0));
    m_busy = 0; mul_v_i = 1'b0; sb.delete(); inflight = 0;
    #2 reset_n_i = 1'b1;
    mul_v_i = 1'b1; mul_result_i = 64'hDEADBEEF_CAFEF00D;
    op_i = 2'b00; opA_i = 32'd3; opB_i = 32'd4; tag_i = 5'd5; v_i = 1'b1; mul_lat = 0;
    step();
    @(negedge clk_i);
    chk("stale_yumi", 128'(mul_yumi_o), 128'(1));
    chk("stale_ready", 128'(ready_o), 128'(0));
    chk("stale_no_v", 128'(v_o), 128'(0));
    tick();
    bad_rdy = 0; bad_stab = 0;
    wait_rsp("post_rst");
    chk("post_rst_result", 128'(last_res), 128'(12));
    chk("post_rst_stable", 128'({bad_rdy, bad_stab}), 128'(0));
    step();
    chk("sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
